// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-zero constant, control bundles.
// Pure declarations; no logic and no latency.
// Control bundles are the fixed output patterns for reset, freeze, load-use bubble, branch and idle.
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit order matches the port order of hazard_ctrl's control outputs.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic mem_wb_flush;
  } hz_ctrl_t;

  // Reset: hold PC/IF-ID, bubble every flushable register, no freeze.
  localparam hz_ctrl_t CTRL_RESET     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  // Memory wait: hold front end and EX/MEM, push a bubble into WB.
  localparam hz_ctrl_t CTRL_FREEZE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // Load-use: hold PC and IF/ID one cycle, insert a bubble into EX.
  localparam hz_ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  // Taken branch: fetch proceeds from the target, the wrong-path fetch becomes a NOP.
  localparam hz_ctrl_t CTRL_BRANCH    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_IDLE      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // A load in EX whose destination is read by the instruction in ID (r0 never hazards).
  function automatic logic load_use_hazard(input logic       mem_read,
                                           input logic [4:0] ex_rt,
                                           input logic [4:0] id_rs,
                                           input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Count visible one cycle after the increment request.
// No backpressure; clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller beside ID: load-use bubbles, branch flush of IF/ID, data-memory freeze.
// Controls are combinational from state and inputs (zero latency); counters/timeout are registered.
// Freeze beats load-use beats branch; a freeze holds ID/EX and EX/MEM until Mem_ready.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic             Branch_taken,
  input  logic             EX_MEM_MemReq,
  input  logic             Mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              freeze_c, lu_c;
  hz_ctrl_t          ctrl_c;

  assign freeze_c = EX_MEM_MemReq & ~Mem_ready;
  assign lu_c     = load_use_hazard(ID_EX_MemRead, ID_EX_RegisterRt,
                                    IF_ID_RegisterRs, IF_ID_RegisterRt);

  // Control decode in priority order; branch is dropped under a stall since its operands are stale.
  always_comb begin
    ctrl_c = CTRL_IDLE;
    if (rst_i) begin
      ctrl_c = CTRL_RESET;
    end else if (freeze_c) begin
      ctrl_c = CTRL_FREEZE;
    end else if (lu_c) begin
      ctrl_c = CTRL_LOAD_USE;
    end else if (Branch_taken) begin
      ctrl_c = CTRL_BRANCH;
    end
  end

  // Wait FSM: enter on a stalled access, leave the first cycle the access is no longer stalled.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      HZ_RUN: begin
        wait_cnt_d = '0;
        if (freeze_c) state_d = HZ_MEM_WAIT;
      end
      HZ_MEM_WAIT: begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
        if (!freeze_c) state_d = HZ_RUN;
      end
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM, wait counter and sticky timeout registers; reset abandons any wait in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (freeze_c | lu_c),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (ctrl_c.if_id_flush),
    .cnt_o (flush_cnt_o)
  );

  assign PC_Write      = ctrl_c.pc_write;
  assign IF_ID_Write   = ctrl_c.if_id_write;
  assign IF_ID_Flush   = ctrl_c.if_id_flush;
  assign ID_EX_Flush   = ctrl_c.id_ex_flush;
  assign Pipe_Freeze   = ctrl_c.pipe_freeze;
  assign MEM_WB_Flush  = ctrl_c.mem_wb_flush;
  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Small timeout and counter width so the timeout and saturation corners are reachable quickly.
module tb_hazard_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  localparam logic [5:0] E_RST  = 6'b001101;
  localparam logic [5:0] E_FRZ  = 6'b000011;
  localparam logic [5:0] E_LU   = 6'b000100;
  localparam logic [5:0] E_BR   = 6'b111000;
  localparam logic [5:0] E_IDLE = 6'b110000;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          ex_mr = 1'b0, br = 1'b0, mq = 1'b0, rdy = 1'b0;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush;
  logic          mem_timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
  logic [5:0]    ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_stall = 0, m_flush = 0, m_mw_run = 0;
  bit m_timeout = 0, m_in_mw = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .IF_ID_RegisterRs (id_rs),
    .IF_ID_RegisterRt (id_rt),
    .ID_EX_MemRead    (ex_mr),
    .ID_EX_RegisterRt (ex_rt),
    .Branch_taken     (br),
    .EX_MEM_MemReq    (mq),
    .Mem_ready        (rdy),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .Pipe_Freeze      (Pipe_Freeze),
    .MEM_WB_Flush     (MEM_WB_Flush),
    .mem_timeout_o    (mem_timeout_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  assign ctrl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush};

  function automatic bit model_lu(logic mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt);
    return mr && (ert != 0) && (ert == rs || ert == rt);
  endfunction

  function automatic logic [5:0] exp_ctrl(bit r, bit f, bit lu, bit b);
    if (r)  return E_RST;
    if (f)  return E_FRZ;
    if (lu) return E_LU;
    if (b)  return E_BR;
    return E_IDLE;
  endfunction

  task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                     input logic [4:0] ert, input logic b, input logic q, input logic rd);
    rst_i = r; id_rs = rs; id_rt = rt; ex_mr = mr; ex_rt = ert; br = b; mq = q; rdy = rd;
  endtask

  // Advance the model by the current cycle's inputs, then cross the clock edge.
  task automatic tick();
    bit f, lu;
    f  = mq && !rdy;
    lu = model_lu(ex_mr, ex_rt, id_rs, id_rt);
    if (rst_i) begin
      m_stall = 0; m_flush = 0; m_timeout = 0; m_in_mw = 0; m_mw_run = 0;
    end else begin
      if (f || lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      else if (br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (m_in_mw) begin
        m_mw_run++;
        if (m_mw_run >= MT) m_timeout = 1;
      end
      m_in_mw = f;
      if (!f) m_mw_run = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_RST) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, E_RST); end
    tick(); tick();
    @(negedge clk_i);
    n_checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || mem_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: stall %0d flush %0d tmo %b want 0 0 0", stall_cnt_o, flush_cnt_o, mem_timeout_o);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_IDLE) begin n_fail++; $display("FAIL idle_ctrl: got %b want %b", ctrl, E_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drv(0, 8, 3, 1, 8, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_LU) begin n_fail++; $display("FAIL lu_rs_ctrl: got %b want %b", ctrl, E_LU); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_IDLE) begin n_fail++; $display("FAIL lu_one_cycle: got %b want %b", ctrl, E_IDLE); end
    n_checks++; if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); end
    tick();
    drv(0, 1, 8, 1, 8, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_LU) begin n_fail++; $display("FAIL lu_rt_ctrl: got %b want %b", ctrl, E_LU); end
    tick();
    // r0 destination never stalls, even when both sources are r0
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_IDLE) begin n_fail++; $display("FAIL lu_r0_ctrl: got %b want %b", ctrl, E_IDLE); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (stall_cnt_o !== 4'd2) begin n_fail++; $display("FAIL lu_r0_cnt: got %0d want 2", stall_cnt_o); end
  endtask

  task automatic test_branch();
    do_reset();
    drv(0, 8, 0, 1, 8, 1, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_LU) begin n_fail++; $display("FAIL br_under_lu: got %b want %b", ctrl, E_LU); end
    tick();
    drv(0, 8, 0, 0, 8, 1, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_BR) begin n_fail++; $display("FAIL br_alone: got %b want %b", ctrl, E_BR); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL br_counts: flush %0d stall %0d want 1 1", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_freeze();
    int nfrz;
    do_reset();
    nfrz = 0;
    for (int i = 0; i < 3; i++) begin
      drv(0, 8, 0, 1, 8, 1, 1, 0);
      @(negedge clk_i);
      n_checks++; if (ctrl !== E_FRZ) begin n_fail++; $display("FAIL freeze_ctrl[%0d]: got %b want %b", i, ctrl, E_FRZ); end
      if (Pipe_Freeze === 1'b1) nfrz++;
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_IDLE) begin n_fail++; $display("FAIL freeze_release: got %b want %b", ctrl, E_IDLE); end
    if (Pipe_Freeze === 1'b1) nfrz++;
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (nfrz != 3 || stall_cnt_o !== 4'd3) begin
      n_fail++; $display("FAIL freeze_len: frozen %0d stall %0d want 3 3", nfrz, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk_i);
      if (c <= 3) begin
        n_checks++; if (mem_timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d]: got %b want 0", c, mem_timeout_o); end
      end else begin
        n_checks++; if (mem_timeout_o !== m_timeout) begin n_fail++; $display("FAIL tmo_rise[%0d]: got %b want %b", c, mem_timeout_o, m_timeout); end
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    n_checks++; if (mem_timeout_o !== 1'b1 || ctrl !== E_IDLE) begin
      n_fail++; $display("FAIL tmo_at_ready: tmo %b ctrl %b want 1 %b", mem_timeout_o, ctrl, E_IDLE);
    end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk_i);
    n_checks++; if (mem_timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", mem_timeout_o); end
    do_reset();
    @(negedge clk_i);
    n_checks++; if (mem_timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_reset: got %b want 0", mem_timeout_o); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drv(0, 0, 0, 0, 0, 1, 1, 0);
      tick();
    end
    drv(1, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_RST) begin n_fail++; $display("FAIL rst_mw_ctrl: got %b want %b", ctrl, E_RST); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (ctrl !== E_IDLE || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || mem_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mw_after: ctrl %b stall %0d flush %0d tmo %b want %b 0 0 0",
                         ctrl, stall_cnt_o, flush_cnt_o, mem_timeout_o, E_IDLE);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin drv(0, 5, 0, 1, 5, 0, 0, 0); tick(); end
    for (int i = 0; i < 20; i++) begin drv(0, 0, 0, 0, 0, 1, 0, 0); tick(); end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    n_checks++; if (stall_cnt_o !== 4'd15 || flush_cnt_o !== 4'd15) begin
      n_fail++; $display("FAIL sat_counts: stall %0d flush %0d want 15 15", stall_cnt_o, flush_cnt_o);
    end
    tick();
  endtask

  task automatic test_random();
    bit prev_f, r, q, rd, b, mr, f;
    logic [4:0] rs, rt, ert;
    prev_f = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      mr  = $urandom_range(0, 1);
      b   = ($urandom_range(0, 2) == 0);
      q   = prev_f ? 1'b1 : ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      drv(r, rs, rt, mr, ert, b, q, rd);
      f = q && !rd;
      @(negedge clk_i);
      n_checks++;
      if (ctrl !== exp_ctrl(r, f, model_lu(mr, ert, rs, rt), b)) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl(r, f, model_lu(mr, ert, rs, rt), b));
      end
      n_checks++;
      if (int'(stall_cnt_o) != m_stall || int'(flush_cnt_o) != m_flush || mem_timeout_o !== m_timeout) begin
        n_fail++; $display("FAIL rand_state[%0d]: stall %0d flush %0d tmo %b want %0d %0d %b",
                           i, stall_cnt_o, flush_cnt_o, mem_timeout_o, m_stall, m_flush, m_timeout);
      end
      prev_f = !r && f;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
